axicb_fifo_reader: RTL and testbench

- Drains a single-clock FIFO (pull/empty/data_out side) and emits a registered valid/ready stream framed into bursts with a last flag.
- Burst length is supplied per command, AXI-style, as beats = len+1. Typical use: W/R data channel emission from a data FIFO, driven by a stored AW/AR length.
- All outputs toward the consumer are registered, and fifo_pull never depends combinationally on m_ready. This breaks the combinational path that a pass-thru FIFO creates.

---
 rtl/axicb_pkg.sv | 12 +
 rtl/axicb_fifo_reader_skid.sv | 89 ++++++++
 rtl/axicb_fifo_reader.sv | 90 +++++++++
 tb/tb_axicb_fifo_reader.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/axicb_pkg.sv
// Shared definitions for the axicb FIFO reader slice.
//   state_t : burst sequencer states
package axicb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_t;

    localparam int SKID_DEPTH = 2;

endpackage

// File: rtl/axicb_fifo_reader_skid.sv
// Two-entry registered output buffer (head + skid) holding {data,last}.
// Words leave strictly in arrival order. rd_data/rd_last come straight
// from the head register, so they hold steady while rd_valid=1 and
// rd_ready=0.
// Ports:
//   aclk, srst, flush           : clock, sync reset, sync abort (drop contents)
//   wr_en, wr_data, wr_last     : write side, one word per cycle
//   rd_valid, rd_ready          : read-side handshake, pop on rd_valid&rd_ready
//   rd_data, rd_last            : head word
//   occ[1:0]                    : registered occupancy, 0..2
module axicb_fifo_reader_skid import axicb_pkg::*; #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  aclk,
    input  logic                  srst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_last,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] head_data;
    logic                  head_last;
    logic [DATA_WIDTH-1:0] skid_data;
    logic                  skid_last;
    logic                  pop;

    assign pop      = (occ != 2'd0) && rd_ready;
    assign rd_valid = (occ != 2'd0);
    assign rd_data  = head_data;
    assign rd_last  = head_last;

    always_ff @(posedge aclk) begin
        if (srst) begin
            occ       <= 2'd0;
            head_data <= '0;
            head_last <= 1'b0;
            skid_data <= '0;
            skid_last <= 1'b0;
        end else if (flush) begin
            occ       <= 2'd0;
            head_last <= 1'b0;
        end else begin
            case (occ)
                2'd0: begin
                    if (wr_en) begin
                        head_data <= wr_data;
                        head_last <= wr_last;
                        occ       <= 2'd1;
                    end
                end
                2'd1: begin
                    if (wr_en && pop) begin
                        head_data <= wr_data;
                        head_last <= wr_last;
                    end else if (wr_en) begin
                        skid_data <= wr_data;
                        skid_last <= wr_last;
                        occ       <= 2'd2;
                    end else if (pop) begin
                        // last is only meaningful with valid; keep it low when empty
                        head_last <= 1'b0;
                        occ       <= 2'd0;
                    end
                end
                default: begin
                    // The reader never writes at occ=2, but a simultaneous
                    // write and pop is still handled as a shift.
                    if (pop) begin
                        head_data <= skid_data;
                        head_last <= skid_last;
                        if (wr_en) begin
                            skid_data <= wr_data;
                            skid_last <= wr_last;
                        end else begin
                            occ <= 2'd1;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/axicb_fifo_reader.sv
// Drains a single-clock FIFO into a registered valid/ready stream framed
// as bursts of cmd_len+1 beats with a last flag. fifo_pull uses only the
// registered buffer occupancy, never m_ready, so no combinational path
// runs from consumer back to the FIFO.
// Ports:
//   aclk, srst, flush                 : clock, sync active-high reset, sync abort
//   cmd_valid, cmd_ready, cmd_len     : burst command (beats = cmd_len+1)
//   fifo_data, fifo_empty, fifo_pull  : FIFO read side
//   m_valid, m_ready, m_data, m_last  : output stream
//   busy                              : burst active or output buffer non-empty
//
// state    | meaning
// ---------+-------------------------------------------------------
// ST_IDLE  | waiting for a command, cmd_ready=1
// ST_BURST | pulling words until remaining reaches 0
module axicb_fifo_reader import axicb_pkg::*; #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  aclk,
    input  logic                  srst,
    input  logic                  flush,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [LEN_WIDTH-1:0]  cmd_len,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_pull,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy
);

    localparam logic [LEN_WIDTH:0] REM_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};

    state_t             state;
    logic [LEN_WIDTH:0] remaining;
    logic [1:0]         occ;
    logic               cmd_fire;
    logic               pull_last;

    assign cmd_ready = !srst && !flush && (state == ST_IDLE);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign fifo_pull = !srst && !flush && (state == ST_BURST) &&
                       !fifo_empty && (occ < 2'd2);
    assign pull_last = (remaining == REM_ONE);
    assign busy      = (state == ST_BURST) || (occ != 2'd0);

    always_ff @(posedge aclk) begin
        if (srst || flush) begin
            state     <= ST_IDLE;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        // extra bit makes cmd_len=all-ones a full 2^LEN_WIDTH burst
                        remaining <= {1'b0, cmd_len} + REM_ONE;
                        state     <= ST_BURST;
                    end
                end
                default: begin
                    if (fifo_pull) begin
                        remaining <= remaining - REM_ONE;
                        if (pull_last) state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    axicb_fifo_reader_skid #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_skid (
        .aclk     (aclk),
        .srst     (srst),
        .flush    (flush),
        .wr_en    (fifo_pull),
        .wr_data  (fifo_data),
        .wr_last  (pull_last),
        .rd_valid (m_valid),
        .rd_ready (m_ready),
        .rd_data  (m_data),
        .rd_last  (m_last),
        .occ      (occ)
    );

endmodule

// File: tb/tb_axicb_fifo_reader.sv
// Directed bench for axicb_fifo_reader. A queue models the source FIFO;
// outputs are sampled on the falling edge, inputs change 1 ns after the
// rising edge.
module tb_axicb_fifo_reader;

    logic       aclk = 1'b0;
    logic       srst = 1'b1;
    logic       flush = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_len = '0;
    logic [7:0] fifo_data = '0;
    logic       fifo_empty = 1'b1;
    logic       fifo_pull;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
    logic       m_last;
    logic       busy;

    axicb_fifo_reader #(.DATA_WIDTH(8), .LEN_WIDTH(8)) dut (
        .aclk       (aclk),
        .srst       (srst),
        .flush      (flush),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_pull  (fifo_pull),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic       srst;
        logic       cmd_valid;
        logic [7:0] cmd_len;
        logic       m_ready;
        logic       e_cmd_ready;
        logic       e_pull;
        logic       e_valid;
        logic [7:0] e_data;
        logic       e_last;
        logic       e_busy;
    } vec_t;

    vec_t tbl[12];

    logic [7:0] fq[$];
    logic [8:0] beats[$];
    int n_vec  = 0;
    int n_miss = 0;
    int n_pull = 0;

    logic       s_cmd_ready, s_pull, s_valid, s_last, s_busy, s_empty;
    logic [7:0] s_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fifo_sync();
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? 8'h00 : fq[0];
    endtask

    task automatic fifo_push(input logic [7:0] w);
        fq.push_back(w);
        fifo_sync();
    endtask

    task automatic step();
        @(negedge aclk);
        s_cmd_ready = cmd_ready;
        s_pull      = fifo_pull;
        s_valid     = m_valid;
        s_data      = m_data;
        s_last      = m_last;
        s_busy      = busy;
        s_empty     = fifo_empty;
        if (s_pull) n_pull++;
        if (m_valid && m_ready) beats.push_back({m_last, m_data});
        @(posedge aclk);
        #1;
        if (s_pull && fq.size() > 0) void'(fq.pop_front());
        fifo_sync();
    endtask

    initial begin
        // srst cmd len m_rdy | cmd_rdy pull valid data last busy
        tbl[0]  = '{1, 1, 8'd0, 1,  0, 0, 0, 8'h00, 0, 0};
        tbl[1]  = '{1, 1, 8'd0, 1,  0, 0, 0, 8'h00, 0, 0};
        tbl[2]  = '{1, 1, 8'd0, 1,  0, 0, 0, 8'h00, 0, 0};
        tbl[3]  = '{0, 1, 8'd0, 1,  1, 0, 0, 8'h00, 0, 0};
        tbl[4]  = '{0, 0, 8'd0, 1,  0, 1, 0, 8'h00, 0, 1};
        tbl[5]  = '{0, 1, 8'd3, 1,  1, 0, 1, 8'hA5, 1, 1};
        tbl[6]  = '{0, 0, 8'd0, 1,  0, 1, 0, 8'hA5, 0, 1};
        tbl[7]  = '{0, 0, 8'd0, 1,  0, 1, 1, 8'h10, 0, 1};
        tbl[8]  = '{0, 0, 8'd0, 1,  0, 1, 1, 8'h11, 0, 1};
        tbl[9]  = '{0, 0, 8'd0, 1,  0, 1, 1, 8'h12, 0, 1};
        tbl[10] = '{0, 0, 8'd0, 1,  1, 0, 1, 8'h13, 1, 1};
        tbl[11] = '{0, 0, 8'd0, 1,  1, 0, 0, 8'h13, 0, 1'b0};

        // reset, single beat, full-rate burst
        fifo_push(8'hA5);
        for (int k = 0; k < 4; k++) fifo_push(8'h10 + 8'(k));
        srst = 1'b1; cmd_valid = 1'b1; m_ready = 1'b1;
        step();
        for (int i = 0; i < 12; i++) begin
            srst      = tbl[i].srst;
            cmd_valid = tbl[i].cmd_valid;
            cmd_len   = tbl[i].cmd_len;
            m_ready   = tbl[i].m_ready;
            step();
            chk($sformatf("row%0d cmd_ready", i), 32'(s_cmd_ready), 32'(tbl[i].e_cmd_ready));
            chk($sformatf("row%0d fifo_pull", i), 32'(s_pull),      32'(tbl[i].e_pull));
            chk($sformatf("row%0d m_valid", i),   32'(s_valid),     32'(tbl[i].e_valid));
            chk($sformatf("row%0d m_data", i),    32'(s_data),      32'(tbl[i].e_data));
            chk($sformatf("row%0d m_last", i),    32'(s_last),      32'(tbl[i].e_last));
            chk($sformatf("row%0d busy", i),      32'(s_busy),      32'(tbl[i].e_busy));
        end
        chk("table beats", 32'(beats.size()), 32'd5);

        // backpressure: 8-beat burst, consumer stalled 10 cycles
        beats.delete();
        for (int k = 0; k < 8; k++) fifo_push(8'h20 + 8'(k));
        cmd_valid = 1'b1; cmd_len = 8'd7; m_ready = 1'b0;
        step();
        chk("bp cmd_ready", 32'(s_cmd_ready), 32'd1);
        cmd_valid = 1'b0;
        n_pull = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (i >= 1) begin
                chk("bp held valid", 32'(s_valid), 32'd1);
                chk("bp held data",  32'(s_data),  32'h20);
            end
        end
        chk("bp pulls while stalled", 32'(n_pull), 32'd2);
        chk("bp fifo words left", 32'(fq.size()), 32'd6);
        m_ready = 1'b1;
        for (int i = 0; i < 40 && beats.size() < 8; i++) step();
        chk("bp beat count", 32'(beats.size()), 32'd8);
        for (int k = 0; k < 8 && k < beats.size(); k++)
            chk($sformatf("bp beat%0d", k), 32'(beats[k]), 32'({(k == 7), 8'h20 + 8'(k)}));

        // starvation: 3 words, then 5 more after 6 cycles
        step();
        beats.delete();
        for (int k = 0; k < 3; k++) fifo_push(8'h30 + 8'(k));
        cmd_valid = 1'b1; cmd_len = 8'd7;
        step();
        chk("st cmd_ready", 32'(s_cmd_ready), 32'd1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 60 && beats.size() < 8; i++) begin
            if (i == 6) for (int k = 3; k < 8; k++) fifo_push(8'h30 + 8'(k));
            step();
            chk("st busy", 32'(s_busy), 32'd1);
            if (s_empty) chk("st no pull when empty", 32'(s_pull), 32'd0);
        end
        chk("st beat count", 32'(beats.size()), 32'd8);
        for (int k = 0; k < 8 && k < beats.size(); k++)
            chk($sformatf("st beat%0d", k), 32'(beats[k]), 32'({(k == 7), 8'h30 + 8'(k)}));

        // flush after two output beats
        step();
        beats.delete();
        for (int k = 0; k < 4; k++) fifo_push(8'h40 + 8'(k));
        cmd_valid = 1'b1; cmd_len = 8'd3; m_ready = 1'b1;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 20 && beats.size() < 2; i++) step();
        chk("fl beats before flush", 32'(beats.size()), 32'd2);
        flush = 1'b1; m_ready = 1'b0; cmd_valid = 1'b1; cmd_len = 8'd0;
        step();
        chk("fl pull in flush", 32'(s_pull), 32'd0);
        chk("fl cmd_ready in flush", 32'(s_cmd_ready), 32'd0);
        flush = 1'b0; cmd_valid = 1'b0; m_ready = 1'b1;
        step();
        chk("fl m_valid after", 32'(s_valid), 32'd0);
        chk("fl m_last after", 32'(s_last), 32'd0);
        chk("fl busy after", 32'(s_busy), 32'd0);
        chk("fl cmd_ready after", 32'(s_cmd_ready), 32'd1);
        chk("fl pull after", 32'(s_pull), 32'd0);
        step();
        chk("fl pull idle", 32'(s_pull), 32'd0);
        chk("fl beats total", 32'(beats.size()), 32'd2);
        fq.delete();
        fifo_push(8'h5A);
        beats.delete();
        cmd_valid = 1'b1; cmd_len = 8'd0;
        step();
        chk("fl new cmd_ready", 32'(s_cmd_ready), 32'd1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 10 && beats.size() < 1; i++) step();
        chk("fl new beat count", 32'(beats.size()), 32'd1);
        if (beats.size() > 0) chk("fl new beat", 32'(beats[0]), 32'h15A);
        step();
        chk("fl final busy", 32'(s_busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
